// File: rtl/mem_port_arbiter_if.sv
// Bundles the core I/D request buses and the shared memory port.
// The arbiter takes the slave view; the core/memory side takes the master view.
interface mem_port_arbiter_if;
  logic        i_en;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_en;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_we;
  logic        d_re;
  logic [2:0]  d_op;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [2:0]  mem_op;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        bus_err;

  modport slave (
    input  i_en, i_addr, d_en, d_addr, d_wdata, d_we, d_re, d_op, mem_ready, mem_rdata,
    output i_rdata, i_ready, d_rdata, d_ready,
           mem_valid, mem_addr, mem_wdata, mem_we, mem_re, mem_op, bus_err
  );

  modport master (
    output i_en, i_addr, d_en, d_addr, d_wdata, d_we, d_re, d_op, mem_ready, mem_rdata,
    input  i_rdata, i_ready, d_rdata, d_ready,
           mem_valid, mem_addr, mem_wdata, mem_we, mem_re, mem_op, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access; data has priority
// bounded by a streak limit, with a per-transaction timeout and stale-fetch discard.
module mem_port_arbiter #(
  parameter int D_STREAK_MAX = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
);
  localparam int SW = (D_STREAK_MAX < 1) ? 1 : $clog2(D_STREAK_MAX + 1);
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_LIM = SW'(D_STREAK_MAX);
  localparam logic [TW-1:0] TO_LIM     = TW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t        r_state, w_next;
  logic [SW-1:0] r_streak;
  logic [TW-1:0] r_wait;
  logic          r_mem_valid, r_mem_we, r_mem_re;
  logic [31:0]   r_mem_addr, r_mem_wdata;
  logic [2:0]    r_mem_op;
  logic          r_i_ready, r_d_ready, r_bus_err;
  logic [31:0]   r_i_rdata, r_d_rdata;
  logic          w_gnt_d, w_gnt_i, w_done, w_tmo, w_keep, w_busy;

  assign w_busy = (r_state == BUSY_I) || (r_state == BUSY_D);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_gnt_d = 1'b0;
    w_gnt_i = 1'b0;
    w_done  = 1'b0;
    w_tmo   = 1'b0;
    w_keep  = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.d_en && (!bus.i_en || (r_streak < STREAK_LIM))) begin
          w_gnt_d = 1'b1;
          w_next  = BUSY_D;
        end else if (bus.i_en) begin
          w_gnt_i = 1'b1;
          w_next  = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        // mem_ready beats a timeout landing in the same cycle
        if (bus.mem_ready) begin
          w_done = 1'b1;
        end else if ((TIMEOUT != 0) && (r_wait == TO_LIM)) begin
          w_done = 1'b1;
          w_tmo  = 1'b1;
        end
        if (w_done) begin
          if (r_state == BUSY_I) begin
            // a fetch whose address moved on (branch/flush) is dropped silently
            w_keep = bus.i_en && (bus.i_addr == r_mem_addr);
            w_next = w_keep ? DONE : IDLE;
          end else begin
            w_keep = bus.d_en;
            w_next = DONE;
          end
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_streak    <= '0;
      r_wait      <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_re    <= 1'b0;
      r_mem_op    <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_i_ready <= 1'b0;
      r_d_ready <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_bus_err <= w_tmo;
      if (w_gnt_d) begin
        r_mem_valid <= 1'b1;
        r_mem_addr  <= bus.d_addr;
        r_mem_wdata <= bus.d_wdata;
        r_mem_we    <= bus.d_we;
        r_mem_re    <= bus.d_re;
        r_mem_op    <= bus.d_op;
      end else if (w_gnt_i) begin
        r_mem_valid <= 1'b1;
        r_mem_addr  <= bus.i_addr;
        r_mem_wdata <= '0;
        r_mem_we    <= 1'b0;
        r_mem_re    <= 1'b1;
        r_mem_op    <= 3'b010;
      end
      if (w_gnt_d || w_gnt_i)           r_wait <= '0;
      else if (w_busy && !bus.mem_ready) r_wait <= r_wait + TW'(1);
      if (w_done) begin
        r_mem_valid <= 1'b0;
        if (r_state == BUSY_I) begin
          r_i_ready <= w_keep;
          r_i_rdata <= (w_keep && !w_tmo) ? bus.mem_rdata : '0;
        end else begin
          r_d_ready <= w_keep;
          r_d_rdata <= (w_keep && !w_tmo) ? bus.mem_rdata : '0;
        end
      end
      if (w_gnt_i)
        r_streak <= '0;
      else if (w_gnt_d && bus.i_en && (r_streak < STREAK_LIM))
        r_streak <= r_streak + SW'(1);
      else if ((r_state == IDLE) && !bus.i_en)
        r_streak <= '0;
    end
  end

  assign bus.mem_valid = r_mem_valid;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_re    = r_mem_re;
  assign bus.mem_op    = r_mem_op;
  assign bus.i_ready   = r_i_ready;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.d_ready   = r_d_ready;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.bus_err   = r_bus_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected grants and responses are queued by the
// stimulus and popped by a monitor whenever the DUT starts a request or pulses a ready.
module tb_mem_port_arbiter;
  logic clk, rst;
  mem_port_arbiter_if bus();

  mem_port_arbiter #(.D_STREAK_MAX(4), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [2:0]  op;
  } req_t;

  typedef struct packed {
    logic        d;
    logic [31:0] rdata;
    logic [31:0] other;
    logic        err;
  } rsp_t;

  req_t        exp_req[$];
  rsp_t        exp_rsp[$];
  req_t        dq[$];
  logic [31:0] iq[$];
  int          tests, fails;
  int          mem_lat;
  bit          resp_on, force_ready;

  function automatic logic [31:0] mem_data(logic [31:0] a);
    case (a)
      32'h100: return 32'h0000_0013;
      32'h200: return 32'h0000_0093;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  function automatic req_t ireq(logic [31:0] a);
    return '{addr: a, wdata: 32'h0, we: 1'b0, re: 1'b1, op: 3'b010};
  endfunction

  function automatic req_t dreq(logic [31:0] a, logic [31:0] wd, logic we, logic [2:0] op);
    return '{addr: a, wdata: wd, we: we, re: !we, op: op};
  endfunction

  function automatic rsp_t irsp(logic [31:0] r);
    return '{d: 1'b0, rdata: r, other: 32'h0, err: 1'b0};
  endfunction

  function automatic rsp_t drsp(logic [31:0] r, logic e);
    return '{d: 1'b1, rdata: r, other: 32'h0, err: e};
  endfunction

  task automatic check(string name, logic [79:0] act, logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory model: answers mem_lat cycles after mem_valid first appears
  task automatic responder();
    int w = 0;
    forever begin
      @(negedge clk);
      if (force_ready) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
      end else if (bus.mem_valid && resp_on) begin
        if (w == mem_lat) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = bus.mem_we ? 32'h0 : mem_data(bus.mem_addr);
        end else begin
          bus.mem_ready = 1'b0;
        end
        w++;
      end else begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h0;
        w = 0;
      end
    end
  endtask

  task automatic monitor();
    logic pv = 1'b0;
    req_t ra, re;
    rsp_t sa, se;
    forever begin
      @(negedge clk);
      if (bus.mem_valid && !pv) begin
        ra = '{addr: bus.mem_addr, wdata: bus.mem_wdata, we: bus.mem_we, re: bus.mem_re, op: bus.mem_op};
        if (exp_req.size() == 0) check("unexpected_grant", 80'(ra), 80'(0));
        else begin
          re = exp_req.pop_front();
          check("grant", 80'(ra), 80'(re));
        end
      end
      pv = bus.mem_valid;
      if (bus.i_ready || bus.d_ready) begin
        sa.d     = bus.d_ready;
        sa.rdata = bus.d_ready ? bus.d_rdata : bus.i_rdata;
        sa.other = bus.d_ready ? bus.i_rdata : bus.d_rdata;
        sa.err   = bus.bus_err;
        check("both_ready", 80'(bus.i_ready && bus.d_ready), 80'(0));
        if (exp_rsp.size() == 0) check("unexpected_ready", 80'(sa), 80'(0));
        else begin
          se = exp_rsp.pop_front();
          check("response", 80'(sa), 80'(se));
        end
      end else if (bus.bus_err) begin
        check("stray_bus_err", 80'(bus.bus_err), 80'(0));
      end
    end
  endtask

  task automatic present();
    if (dq.size() != 0) begin
      bus.d_en = 1'b1;  bus.d_addr = dq[0].addr; bus.d_wdata = dq[0].wdata;
      bus.d_we = dq[0].we; bus.d_re = dq[0].re; bus.d_op = dq[0].op;
    end else bus.d_en = 1'b0;
    if (iq.size() != 0) begin
      bus.i_en = 1'b1; bus.i_addr = iq[0];
    end else bus.i_en = 1'b0;
  endtask

  // core model: each port holds its request until ready, then presents the next
  task automatic run_ports(int budget);
    int n = 0;
    present();
    while ((dq.size() != 0 || iq.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.d_ready) void'(dq.pop_front());
      if (bus.i_ready) void'(iq.pop_front());
      present();
    end
    if (n >= budget) check("run_ports_timeout", 80'(n), 80'(budget - 1));
  endtask

  task automatic wait_valid(string name, int budget);
    int n = 0;
    while (!bus.mem_valid && n < budget) begin @(negedge clk); n++; end
    if (!bus.mem_valid) check(name, 80'(bus.mem_valid), 80'(1));
  endtask

  task automatic summary();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
  endtask

  initial begin
    int n, hits;
    tests = 0; fails = 0; mem_lat = 0; resp_on = 1'b1; force_ready = 1'b0;
    rst = 1'b0;
    bus.i_en = 0; bus.i_addr = 0; bus.d_en = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.d_we = 0; bus.d_re = 0; bus.d_op = 0; bus.mem_ready = 0; bus.mem_rdata = 0;
    fork
      responder();
      monitor();
      begin
        #500000;
        check("watchdog", 80'(1), 80'(0));
        summary();
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) @(negedge clk);
    check("reset_mem_side", {bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.mem_re, bus.mem_op}, 80'(0));
    check("reset_core_side", {bus.i_ready, bus.i_rdata, bus.d_ready, bus.d_rdata, bus.bus_err}, 80'(0));
    rst = 1'b1;
    @(negedge clk);

    // single fetch: ready two edges after the request is first sampled
    exp_req.push_back(ireq(32'h100));
    exp_rsp.push_back(irsp(32'h13));
    bus.i_en = 1'b1; bus.i_addr = 32'h100;
    n = 0;
    while (!bus.i_ready && n < 20) begin @(negedge clk); n++; end
    check("fetch_latency", 80'(n), 80'(2));
    bus.i_en = 1'b0;
    repeat (2) @(negedge clk);

    // simultaneous store and fetch: data first
    exp_req.push_back(dreq(32'h2000, 32'hDEAD_BEEF, 1'b1, 3'b010));
    exp_req.push_back(ireq(32'h100));
    exp_rsp.push_back(drsp(32'h0, 1'b0));
    exp_rsp.push_back(irsp(32'h13));
    dq.push_back(dreq(32'h2000, 32'hDEAD_BEEF, 1'b1, 3'b010));
    iq.push_back(32'h100);
    run_ports(100);
    repeat (2) @(negedge clk);

    // starvation bound: D,D,D,D,I,D,D,I
    for (int k = 0; k < 6; k++) dq.push_back(dreq(32'h3000 + 32'(4 * k), 32'h0, 1'b0, 3'b010));
    iq.push_back(32'h400);
    iq.push_back(32'h404);
    for (int k = 0; k < 4; k++) begin
      exp_req.push_back(dq[k]);
      exp_rsp.push_back(drsp(32'hA5A5_3000 + 32'(4 * k), 1'b0));
    end
    exp_req.push_back(ireq(32'h400));  exp_rsp.push_back(irsp(32'hA5A5_0400));
    exp_req.push_back(dq[4]);          exp_rsp.push_back(drsp(32'hA5A5_3010, 1'b0));
    exp_req.push_back(dq[5]);          exp_rsp.push_back(drsp(32'hA5A5_3014, 1'b0));
    exp_req.push_back(ireq(32'h404));  exp_rsp.push_back(irsp(32'hA5A5_0404));
    run_ports(300);
    repeat (2) @(negedge clk);

    // flush: fetch address changes while in flight, stale fetch is discarded
    mem_lat = 3;
    exp_req.push_back(ireq(32'h100));
    exp_req.push_back(ireq(32'h200));
    exp_rsp.push_back(irsp(32'h93));
    bus.i_en = 1'b1; bus.i_addr = 32'h100;
    wait_valid("flush_grant_timeout", 10);
    bus.i_addr = 32'h200;
    n = 0;
    while (!bus.i_ready && n < 40) begin @(negedge clk); n++; end
    check("flush_ready_seen", 80'(bus.i_ready), 80'(1));
    bus.i_en = 1'b0;
    mem_lat = 0;
    repeat (2) @(negedge clk);

    // timeout: counter reaches 8 after 8 idle busy cycles, fires on the 9th
    resp_on = 1'b0;
    exp_req.push_back(dreq(32'h3000, 32'h0, 1'b0, 3'b100));
    exp_rsp.push_back(drsp(32'h0, 1'b1));
    dq.push_back(dreq(32'h3000, 32'h0, 1'b0, 3'b100));
    present();
    wait_valid("timeout_grant_timeout", 10);
    n = 0;
    while (bus.mem_valid && n < 40) begin @(negedge clk); n++; end
    check("timeout_valid_cycles", 80'(n), 80'(9));
    check("timeout_err_ready", {bus.bus_err, bus.d_ready, bus.d_rdata}, {1'b1, 1'b1, 32'h0});
    void'(dq.pop_front());
    present();
    resp_on = 1'b1;
    repeat (2) @(negedge clk);
    check("timeout_back_idle", {bus.mem_valid, bus.bus_err, bus.d_ready}, 80'(0));

    // mem_ready in the same cycle the timeout would fire: ready wins
    mem_lat = 8;
    exp_req.push_back(dreq(32'h3010, 32'h0, 1'b0, 3'b010));
    exp_rsp.push_back(drsp(32'hA5A5_3010, 1'b0));
    dq.push_back(dreq(32'h3010, 32'h0, 1'b0, 3'b010));
    run_ports(60);
    mem_lat = 0;
    repeat (2) @(negedge clk);

    // d_en dropped mid-flight: access completes, no d_ready
    resp_on = 1'b0;
    exp_req.push_back(dreq(32'h6000, 32'h0, 1'b0, 3'b010));
    dq.push_back(dreq(32'h6000, 32'h0, 1'b0, 3'b010));
    present();
    wait_valid("drop_grant_timeout", 10);
    void'(dq.pop_front());
    present();
    resp_on = 1'b1;
    hits = 0;
    repeat (6) begin @(negedge clk); hits += int'(bus.d_ready); end
    check("dropped_no_ready", 80'(hits), 80'(0));
    check("dropped_completed", 80'(bus.mem_valid), 80'(0));

    // reset in BUSY_D: everything clears, late mem_ready ignored
    resp_on = 1'b0;
    exp_req.push_back(dreq(32'h5000, 32'h1122_3344, 1'b1, 3'b001));
    dq.push_back(dreq(32'h5000, 32'h1122_3344, 1'b1, 3'b001));
    present();
    wait_valid("rst_grant_timeout", 10);
    @(negedge clk);
    rst = 1'b0;
    void'(dq.pop_front());
    present();
    @(negedge clk);
    check("midrst_mem_side", {bus.mem_valid, bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.mem_re, bus.mem_op}, 80'(0));
    check("midrst_core_side", {bus.i_ready, bus.i_rdata, bus.d_ready, bus.d_rdata, bus.bus_err}, 80'(0));
    rst = 1'b1;
    force_ready = 1'b1;
    hits = 0;
    repeat (4) begin @(negedge clk); hits += int'(bus.d_ready | bus.i_ready | bus.mem_valid | bus.bus_err); end
    force_ready = 1'b0;
    resp_on = 1'b1;
    check("late_ready_ignored", 80'(hits), 80'(0));

    repeat (3) @(negedge clk);
    check("req_queue_drained", 80'(exp_req.size()), 80'(0));
    check("rsp_queue_drained", 80'(exp_rsp.size()), 80'(0));
    summary();
    $finish;
  end
endmodule
